// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage of the SQED core.
package mem_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Data memory is word-only: low address bits are dropped, never trapped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_access_unit_if
  import mem_pkg::*;
  ();

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: each edge either loads the retiring instruction or a bubble.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [XLEN-1:0]   wb_data_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              memtoReg_in,
  input  logic              regWrite_in,
  input  logic              qed_vld_in,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              memtoReg_out,
  output logic              regWrite_out,
  output logic              qed_vld_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_out  <= '0;
      rd_out       <= '0;
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      qed_vld_out  <= 1'b0;
    end else if (load) begin
      wb_data_out  <= wb_data_in;
      rd_out       <= rd_in;
      memtoReg_out <= memtoReg_in;
      regWrite_out <= regWrite_in;
      qed_vld_out  <= qed_vld_in;
    end else begin
      // Bubble: nothing retires, so the QED valid bit is cleared with regWrite.
      wb_data_out  <= '0;
      rd_out       <= '0;
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      qed_vld_out  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory accesses, stalls EX/MEM while one is outstanding,
// and feeds the MEM/WB register with either the retiring instruction or a bubble.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   alu_res_in,
  input  logic [XLEN-1:0]   reg_data2_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memtoReg_in,
  input  logic              regWrite_in,
  input  logic              branch_in,
  input  logic              alu_zero_in,
  input  logic              qed_vld_in,
  mem_access_unit_if.master dmem,
  output logic              pipe_stall,
  output logic              pc_src,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              memtoReg_out,
  output logic              regWrite_out,
  output logic              qed_vld_out
);

  mem_state_t      state_reg;
  mem_state_t      state_next;
  logic            req_reg;
  logic            we_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rdata_reg;

  logic            acc;
  logic            is_load;
  logic            issue;
  logic            complete;
  logic            wb_load;
  logic [XLEN-1:0] wb_data_next;

  assign acc     = memRead_in | memWrite_in;
  // A store wins when both flags are set.
  assign is_load = memRead_in & ~memWrite_in;
  assign pc_src  = branch_in & alu_zero_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pipe_stall   = 1'b0;
    issue        = 1'b0;
    complete     = 1'b0;
    wb_load      = 1'b0;
    wb_data_next = alu_res_in;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          pipe_stall = 1'b1;
          issue      = 1'b1;
          state_next = WAIT;
        end else begin
          wb_load = 1'b1;
        end
      end
      WAIT: begin
        pipe_stall = 1'b1;
        if (dmem.dmem_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished access here, so acc must not re-issue it.
        wb_load    = 1'b1;
        state_next = IDLE;
        if (is_load) begin
          wb_data_next = rdata_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (issue) begin
        req_reg   <= 1'b1;
        we_reg    <= memWrite_in;
        addr_reg  <= word_align(alu_res_in);
        wdata_reg <= reg_data2_in;
      end
      if (complete) begin
        req_reg   <= 1'b0;
        rdata_reg <= dmem.dmem_rdata;
      end
    end
  end

  assign dmem.dmem_req   = req_reg;
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_wdata = wdata_reg;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (wb_load),
    .wb_data_in   (wb_data_next),
    .rd_in        (rd_in),
    .memtoReg_in  (memtoReg_in),
    .regWrite_in  (regWrite_in),
    .qed_vld_in   (qed_vld_in),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .memtoReg_out (memtoReg_out),
    .regWrite_out (regWrite_out),
    .qed_vld_out  (qed_vld_out)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed instructions, a per-cycle timeline model and
// a compare process that checks every output on every falling edge.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [XLEN-1:0]   alu_res_in;
  logic [XLEN-1:0]   reg_data2_in;
  logic [REG_AW-1:0] rd_in;
  logic              memRead_in;
  logic              memWrite_in;
  logic              memtoReg_in;
  logic              regWrite_in;
  logic              branch_in;
  logic              alu_zero_in;
  logic              qed_vld_in;
  logic              pipe_stall;
  logic              pc_src;
  logic [XLEN-1:0]   wb_data_out;
  logic [REG_AW-1:0] rd_out;
  logic              memtoReg_out;
  logic              regWrite_out;
  logic              qed_vld_out;

  mem_access_unit_if dmem ();

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_res_in   (alu_res_in),
    .reg_data2_in (reg_data2_in),
    .rd_in        (rd_in),
    .memRead_in   (memRead_in),
    .memWrite_in  (memWrite_in),
    .memtoReg_in  (memtoReg_in),
    .regWrite_in  (regWrite_in),
    .branch_in    (branch_in),
    .alu_zero_in  (alu_zero_in),
    .qed_vld_in   (qed_vld_in),
    .dmem         (dmem),
    .pipe_stall   (pipe_stall),
    .pc_src       (pc_src),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .memtoReg_out (memtoReg_out),
    .regWrite_out (regWrite_out),
    .qed_vld_out  (qed_vld_out)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        qed;
  } wb_t;

  typedef struct packed {
    logic        stall;
    logic        pc;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    wb_t         wb;
  } exp_t;

  localparam wb_t BUBBLE = '0;

  exp_t        q[$];
  int          vectors = 0;
  int          fails   = 0;
  bit          check_en = 1'b0;
  int          stall_obs;
  int          qed_obs;
  wb_t         cur_wb;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (check_en && q.size() != 0) begin
      e = q.pop_front();
      chk("pipe_stall",   pipe_stall,   e.stall);
      chk("pc_src",       pc_src,       e.pc);
      chk("dmem_req",     dmem.dmem_req, e.req);
      chk("dmem_we",      dmem.dmem_we,  e.we);
      chk("dmem_addr",    dmem.dmem_addr, e.addr);
      chk("dmem_wdata",   dmem.dmem_wdata, e.wdata);
      chk("wb_data_out",  wb_data_out,  e.wb.data);
      chk("rd_out",       rd_out,       e.wb.rd);
      chk("memtoReg_out", memtoReg_out, e.wb.m2r);
      chk("regWrite_out", regWrite_out, e.wb.rw);
      chk("qed_vld_out",  qed_vld_out,  e.wb.qed);
    end
  end

  // One clock of the timeline: record what this cycle must show, then what MEM/WB takes next.
  task automatic tick(input logic stall_e, input logic req_e, input wb_t nxt);
    exp_t e;
    e.stall = stall_e;
    e.pc    = branch_in & alu_zero_in;
    e.req   = req_e;
    e.we    = exp_we;
    e.addr  = exp_addr;
    e.wdata = exp_wdata;
    e.wb    = cur_wb;
    q.push_back(e);
    cur_wb = nxt;
    #2;
    if (pipe_stall)  stall_obs++;
    if (qed_vld_out) qed_obs++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic qed, input logic br, input logic z);
    alu_res_in   = alu;
    reg_data2_in = d2;
    rd_in        = rd;
    memRead_in   = mr;
    memWrite_in  = mw;
    memtoReg_in  = m2r;
    regWrite_in  = rw;
    qed_vld_in   = qed;
    branch_in    = br;
    alu_zero_in  = z;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic m2r,
                        input logic rw, input logic qed, input logic br, input logic z,
                        input logic ack);
    wb_t res;
    set_ex(alu, 32'h0, rd, 1'b0, 1'b0, m2r, rw, qed, br, z);
    dmem.dmem_ack   = ack;
    dmem.dmem_rdata = $urandom;
    res = {alu, rd, m2r, rw, qed};
    $display("txn alu  alu=%h rd=%0d rw=%0b qed=%0b ack=%0b", alu, rd, rw, qed, ack);
    tick(1'b0, 1'b0, res);
  endtask

  // d = number of WAIT cycles; ack is raised on the last of them.
  task automatic access(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic qed, input int d, input logic [31:0] rval);
    wb_t res;
    set_ex(alu, d2, rd, mr, mw, m2r, rw, qed, 1'b0, 1'b0);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = $urandom;
    $display("txn mem  addr=%h wdata=%h rd=%0d rd/wr=%0b%0b wait=%0d rdata=%h",
             alu, d2, rd, mr, mw, d, rval);
    tick(1'b1, 1'b0, BUBBLE);
    exp_we    = mw;
    exp_addr  = alu & 32'hFFFF_FFFC;
    exp_wdata = d2;
    for (int k = 1; k <= d; k++) begin
      dmem.dmem_ack   = (k == d);
      dmem.dmem_rdata = (k == d) ? rval : $urandom;
      tick(1'b1, 1'b1, BUBBLE);
    end
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = $urandom;
    res = {((mr && !mw) ? rval : alu), rd, m2r, rw, qed};
    tick(1'b0, 1'b0, res);
  endtask

  task automatic model_reset();
    cur_wb    = BUBBLE;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    model_reset();
    stall_obs = 0;
    qed_obs   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req",   dmem.dmem_req, 32'd0);
    chk("rst_dmem_addr",  dmem.dmem_addr, 32'd0);
    chk("rst_wb_data",    wb_data_out, 32'd0);
    chk("rst_regWrite",   regWrite_out, 32'd0);
    reset    = 1'b0;
    check_en = 1'b1;

    // Plain ALU ops, 1-cycle latency through MEM/WB.
    alu_op(32'h1234, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("alu_wb_data",  wb_data_out, 32'h1234);
    chk("alu_rd",       rd_out, 32'd5);
    chk("alu_regWrite", regWrite_out, 32'd1);
    chk("alu_qed",      qed_vld_out, 32'd1);
    chk("alu_stall",    pipe_stall, 32'd0);
    alu_op(32'h55, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Load with ack after 3 WAIT cycles.
    stall_obs = 0;
    access(32'h100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    chk("load_stall_cycles", stall_obs, 32'd4);
    chk("load_wb_data",      wb_data_out, 32'hDEADBEEF);
    chk("load_memtoReg",     memtoReg_out, 32'd1);
    chk("load_addr",         dmem.dmem_addr, 32'h100);
    chk("load_we",           dmem.dmem_we, 32'd0);

    // Misaligned store, ack in the first WAIT cycle.
    stall_obs = 0;
    access(32'h203, 32'hCAFE, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h0BAD0BAD);
    chk("store_stall_cycles", stall_obs, 32'd2);
    chk("store_addr",         dmem.dmem_addr, 32'h200);
    chk("store_wdata",        dmem.dmem_wdata, 32'hCAFE);
    chk("store_we",           dmem.dmem_we, 32'd1);
    chk("store_regWrite",     regWrite_out, 32'd0);

    // Spurious acks in IDLE, then an access with both read and write set.
    alu_op(32'h77, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    alu_op(32'h78, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("spurious_ack_stall", pipe_stall, 32'd0);
    chk("spurious_ack_req",   dmem.dmem_req, 32'd0);
    access(32'h300, 32'h1111, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h5555AAAA);
    chk("both_we",      dmem.dmem_we, 32'd1);
    chk("both_wb_data", wb_data_out, 32'h300);

    // Back-to-back loads: each retires exactly once.
    alu_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    qed_obs = 0;
    access(32'h400, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 32'h1111AAAA);
    chk("b2b_a_wb_data", wb_data_out, 32'h1111AAAA);
    access(32'h404, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 32'h2222BBBB);
    alu_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_qed_pulses", qed_obs, 32'd2);

    // Reset during WAIT drops the request at once; a later ack is ignored.
    alu_op(32'hAB, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(32'h500, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    dmem.dmem_ack = 1'b0;
    $display("txn mem  addr=00000500 load, reset during WAIT");
    tick(1'b1, 1'b0, BUBBLE);
    exp_we   = 1'b0;
    exp_addr = 32'h500;
    tick(1'b1, 1'b1, BUBBLE);
    check_en = 1'b0;
    chk("pre_rst_req", dmem.dmem_req, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midwait_rst_req",      dmem.dmem_req, 32'd0);
    chk("midwait_rst_regWrite", regWrite_out, 32'd0);
    chk("midwait_rst_qed",      qed_vld_out, 32'd0);
    set_ex(32'hC0, 32'h0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_en = 1'b1;
    alu_op(32'hC0, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    alu_op(32'hC4, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("late_ack_req",  dmem.dmem_req, 32'd0);
    chk("late_ack_addr", dmem.dmem_addr, 32'd0);

    // Reset clears a retiring instruction in the same cycle.
    alu_op(32'hEE, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_en = 1'b0;
    chk("pre_rst_regWrite", regWrite_out, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_clr_regWrite", regWrite_out, 32'd0);
    chk("rst_clr_qed",      qed_vld_out, 32'd0);
    chk("rst_clr_wb_data",  wb_data_out, 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
